// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core (fetch/decode/execute/memory/writeback).
// Define CTRL_PERF_EN to add the cycle_count/retired_count performance counters.
module multicycle_ctrl #(
  parameter int D_WIDTH    = 32,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [D_WIDTH-1:0]    instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            imm_src,
  output logic                  illegal,
  output logic                  instr_done
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           retired_count
`endif
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'd3, OP_SW = 7'd35, OP_I = 7'd19, OP_R = 7'd51, OP_B = 7'd99, OP_JAL = 7'd111;
  state_t state, state_next;
  logic [6:0] op;
  logic [2:0] f3, alu_op;
  logic alu_ok, unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign unused_bits = ^{instr[D_WIDTH-1:31], instr[29:15], instr[11:7]};
  assign alu_ok = f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
  assign alu_op = f3 == 3'b000 ? ((op == OP_R && instr[30]) ? 3'b001 : 3'b000) :
                  f3 == 3'b010 ? 3'b101 : f3 == 3'b110 ? 3'b011 : 3'b010;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_next;
  // Outputs are forced low combinationally while rst is high, so an in-flight strobe drops at once.
  always_comb begin
    state_next = state;
    mem_req = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_control = '0;
    imm_src = 2'b00;
    illegal = 1'b0;
    instr_done = 1'b0;
    if (!rst)
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          alu_src_b = 2'b10;
          ir_write = mem_ready;
          pc_write = mem_ready;
          state_next = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src = 2'b10;
          state_next = (op == OP_LW || op == OP_SW) ? (f3 == 3'b010 ? MEMADR : ILLEGAL) :
                       op == OP_R ? (alu_ok ? EXEC_R : ILLEGAL) :
                       op == OP_I ? (alu_ok ? EXEC_I : ILLEGAL) :
                       op == OP_B ? (f3[2:1] == 2'b00 ? BRANCH : ILLEGAL) :
                       op == OP_JAL ? JAL : ILLEGAL;
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src = op == OP_SW ? 2'b01 : 2'b00;
          state_next = op == OP_SW ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          state_next = mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          result_src = 2'b01;
          reg_write = 1'b1;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_write = 1'b1;
          adr_src = 1'b1;
          instr_done = mem_ready;
          state_next = mem_ready ? FETCH : MEMWRITE;
        end
        EXEC_R: begin
          alu_src_a = 2'b10;
          alu_control = ALU_CTRL_W'(alu_op);
          state_next = ALUWB;
        end
        EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_control = ALU_CTRL_W'(alu_op);
          state_next = ALUWB;
        end
        ALUWB: begin
          reg_write = 1'b1;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        BRANCH: begin
          alu_src_a = 2'b10;
          alu_control = ALU_CTRL_W'(3'b001);
          pc_write = zero ^ f3[0];
          instr_done = 1'b1;
          state_next = FETCH;
        end
        JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write = 1'b1;
          imm_src = 2'b11;
          state_next = ALUWB;
        end
        ILLEGAL: illegal = 1'b1;
        default: state_next = FETCH;
      endcase
  end
`ifdef CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cycle_count <= '0;
      retired_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      retired_count <= retired_count + 32'(instr_done);
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; a per-instruction model predicts every cycle's control outputs.
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = '0;
  logic mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, illegal, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_count, retired_count;
`endif
  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .illegal(illegal), .instr_done(instr_done)
`ifdef CTRL_PERF_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { logic [18:0] v; string tag; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [18:0] mon_got;
  int n_cmp = 0, n_err = 0, cyc_m = 0, ret_m = 0;
  function automatic logic [18:0] mk(input bit req, adr, irw, pcw, mw, rw, input logic [1:0] rs, a, b,
                                     input logic [2:0] alu, input logic [1:0] imm, input bit ill, done);
    return {req, adr, irw, pcw, mw, rw, rs, a, b, alu, imm, ill, done};
  endfunction
  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_got = {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_control, imm_src, illegal, instr_done};
      n_cmp++;
      if (mon_got !== mon_e.v) begin
        n_err++;
        $display("FAIL %s got=%b exp=%b", mon_e.tag, mon_got, mon_e.v);
      end
    end
  task automatic perf_check();
`ifdef CTRL_PERF_EN
    n_cmp++;
    if (cycle_count !== 32'(cyc_m) || retired_count !== 32'(ret_m)) begin
      n_err++;
      $display("FAIL perf cycles=%0d retired=%0d exp %0d/%0d", cycle_count, retired_count, cyc_m, ret_m);
    end
`endif
  endtask
  // One clock slot: drive just after the rising edge, expectation checked at the falling edge.
  task automatic slot(input bit r, input bit mr, input logic [31:0] ins, input bit z,
                      input logic [18:0] v, input string tag);
    @(posedge clk);
    #1;
    if (r && !rst) perf_check();
    rst = r;
    mem_ready = mr;
    instr = ins;
    zero = z;
    exp_q.push_back('{v: v, tag: tag});
    if (r) begin
      cyc_m = 0;
      ret_m = 0;
    end else begin
      cyc_m++;
      ret_m += int'(v[0]);
    end
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) slot(1'b1, rb(), instr, zero, '0, "rst");
  endtask
  // Expected cycle sequence of one instruction; bit 19 of each entry is the mem_ready to drive.
  task automatic run_instr(input logic [31:0] ins, input bit z, input int wf, input int wm,
                           input int lim, input string tag, output bit term);
    logic [19:0] q[$];
    logic [6:0] op;
    logic [2:0] f3;
    int al;
    op = ins[6:0];
    f3 = ins[14:12];
    term = 1'b0;
    for (int i = 0; i < wf; i++) q.push_back({1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0)});
    q.push_back({1'b1, mk(1, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0)});
    q.push_back({rb(), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0)});
    al = f3 == 0 ? ((op == 51 && ins[30]) ? 1 : 0) : f3 == 2 ? 5 : f3 == 6 ? 3 : f3 == 7 ? 2 : -1;
    if ((op == 3 || op == 35) && f3 == 2) begin
      q.push_back({rb(), mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, op == 35 ? 2'd1 : 2'd0, 0, 0)});
      if (op == 3) begin
        for (int i = 0; i < wm; i++) q.push_back({1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        q.push_back({1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        q.push_back({rb(), mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1)});
      end else begin
        for (int i = 0; i < wm; i++) q.push_back({1'b0, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)});
        q.push_back({1'b1, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)});
      end
    end else if ((op == 51 || op == 19) && al >= 0) begin
      q.push_back({rb(), mk(0, 0, 0, 0, 0, 0, 0, 2, op == 19 ? 2'd1 : 2'd0, 3'(al), 0, 0, 0)});
      q.push_back({rb(), mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)});
    end else if (op == 99 && f3 < 2) begin
      q.push_back({rb(), mk(0, 0, 0, z ^ f3[0], 0, 0, 0, 2, 0, 1, 0, 0, 1)});
    end else if (op == 111) begin
      q.push_back({rb(), mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 3, 0, 0)});
      q.push_back({rb(), mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)});
    end else begin
      term = 1'b1;
      for (int i = 0; i < 3; i++) q.push_back({rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    end
    for (int i = 0; i < q.size() && (lim < 0 || i < lim); i++)
      slot(1'b0, q[i][19], ins, z, q[i][18:0], $sformatf("%s.%0d", tag, i));
  endtask
  task automatic random_run(input int n);
    logic [31:0] r;
    logic [6:0] op;
    logic [2:0] f;
    int k, lim;
    bit term;
    for (int j = 0; j < n; j++) begin
      k = $urandom_range(0, 6);
      r = $urandom;
      f = 3'($urandom_range(0, 7));
      op = k == 0 ? 7'd3 : k == 1 ? 7'd35 : k == 2 ? 7'd51 : k == 3 ? 7'd19 : k == 4 ? 7'd99 :
           k == 5 ? 7'd111 : 7'($urandom_range(0, 127));
      if (k < 2 && $urandom_range(0, 3) != 0) f = 3'd2;
      if (k == 4) f = 3'($urandom_range(0, 3));
      r[6:0] = op;
      r[14:12] = f;
      lim = $urandom_range(0, 7) == 0 ? $urandom_range(1, 4) : -1;
      run_instr(r, rb(), $urandom_range(0, 2), $urandom_range(0, 2), lim, $sformatf("rnd%0d", j), term);
      if (term || lim >= 0) do_reset($urandom_range(1, 2));
    end
  endtask
  initial begin
    bit t;
    do_reset(2);
    run_instr(32'h00500093, 1'b0, 0, 0, -1, "addi", t);
    run_instr(32'h00802103, 1'b0, 0, 0, -1, "lw0", t);
    run_instr(32'h00202623, 1'b0, 0, 0, -1, "sw0", t);
    run_instr(32'hFE009CE3, 1'b0, 0, 0, -1, "bne0", t);
    do_reset(1);
    run_instr(32'h00802103, 1'b0, 0, 2, -1, "lw_w2", t);
    run_instr(32'h00202623, 1'b0, 1, 2, -1, "sw_w", t);
    run_instr(32'hFE009CE3, 1'b1, 0, 0, -1, "bne_z1", t);
    run_instr(32'hFE009CE3, 1'b0, 2, 0, -1, "bne_z0", t);
    run_instr(32'h40208033, 1'b0, 0, 0, -1, "sub", t);
    run_instr(32'h0080006F, 1'b0, 1, 0, -1, "jal", t);
    run_instr(32'h0000007F, 1'b0, 0, 0, -1, "ill", t);
    do_reset(2);
    run_instr(32'h00202623, 1'b0, 0, 3, 4, "sw_abort", t);
    do_reset(1);
    random_run(60);
    do_reset(1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
